// File: rtl/rom_fetch_bridge.sv
// Instruction-fetch bridge: single-word holding buffer in front of a req/ack bus with timeout.
// Optional FETCH_STALL_COUNTER_EN adds a saturating stall_count output.
module rom_fetch_bridge #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_WIDTH  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rom_chip_enable,
  input  logic [ADDR_WIDTH-1:0] rom_addr,
  output logic [DATA_WIDTH-1:0] rom_data,
  output logic                  fetch_stall,
  output logic                  fetch_fault,
  output logic                  bus_req,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  input  logic                  bus_ack,
  input  logic [DATA_WIDTH-1:0] bus_rdata
`ifdef FETCH_STALL_COUNTER_EN
  ,
  output logic [31:0]           stall_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_next_state;
  logic                     r_held_valid;
  logic [ADDR_WIDTH-1:0]    r_held_addr;
  logic [DATA_WIDTH-1:0]    r_held_data;
  logic [TIMEOUT_WIDTH-1:0] r_count;
  logic                     r_bus_req;
  logic [ADDR_WIDTH-1:0]    r_bus_addr;
  logic                     r_abandon;

  logic                     w_hit;
  logic                     w_issue;
  logic                     w_fill;
  logic                     w_stall;
  logic [DATA_WIDTH-1:0]    w_rom_data;

  assign w_hit = r_held_valid && (rom_addr == r_held_addr);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_rom_data   = '0;
    w_stall      = 1'b0;
    w_issue      = 1'b0;
    w_fill       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rom_chip_enable) begin
          if (w_hit) begin
            w_rom_data = r_held_data;
          end else if (rom_addr[1:0] != 2'b00) begin
            w_next_state = S_FAULT;
          end else begin
            w_stall      = 1'b1;
            w_issue      = 1'b1;
            w_next_state = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        w_stall = 1'b1;
        // Ack takes priority over an expiring timeout on the same edge
        if (bus_ack) begin
          w_fill       = 1'b1;
          w_next_state = S_IDLE;
        end else if (r_count == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
          w_next_state = S_FAULT;
        end
      end
      S_FAULT: begin
        w_next_state = S_FAULT;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Request, timeout and holding-buffer registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_held_valid <= 1'b0;
      r_held_addr  <= '0;
      r_held_data  <= '0;
      r_count      <= '0;
      r_bus_req    <= 1'b0;
      r_bus_addr   <= '0;
      r_abandon    <= 1'b0;
    end else begin
      if (w_issue) begin
        r_bus_req  <= 1'b1;
        r_bus_addr <= rom_addr;
        r_count    <= '0;
        r_abandon  <= 1'b0;
      end
      if (r_state == S_WAIT) begin
        if (!rom_chip_enable) r_abandon <= 1'b1;
        if (w_fill) begin
          r_held_data  <= bus_rdata;
          r_held_addr  <= r_bus_addr;
          // A fetch the core gave up on mid-flight is not kept
          r_held_valid <= rom_chip_enable && !r_abandon;
          r_bus_req    <= 1'b0;
        end else if (w_next_state == S_FAULT) begin
          r_bus_req <= 1'b0;
        end else begin
          r_count <= r_count + TIMEOUT_WIDTH'(1);
        end
      end
    end
  end

`ifdef FETCH_STALL_COUNTER_EN
  logic [31:0] r_stall_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stall_count <= '0;
    end else if (fetch_stall && (r_stall_count != 32'hFFFF_FFFF)) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign stall_count = r_stall_count;
`endif

  // Combinational core-side outputs are forced quiet while reset is held
  assign rom_data    = reset ? w_rom_data : '0;
  assign fetch_stall = reset && w_stall;
  assign fetch_fault = (r_state == S_FAULT);
  assign bus_req     = r_bus_req;
  assign bus_addr    = r_bus_addr;

endmodule
